dcache_wb_dm: RTL and testbench
===============================

Name: dcache_wb_dm

Overview:
- Direct-mapped, write-back, write-allocate data cache between the RISC-V core's data port and the 128-bit slow data memory.
- The core issues 32-bit word reads and writes. The cache serves hits combinationally and stalls the core on misses.
- On a miss it writes back a dirty victim line, then allocates the missing line, using the slow memory's read/write/ready handshake.

Parameters:
- INDEX_W, 3, log2 of the number of lines (default 8 lines of 4 words, 128 bits each).
- TAG_W, 25, tag width; must equal 28 - INDEX_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- proc_reset  input  1  synchronous, active-high reset.
- proc_read  input  1  core word read request.
- proc_write  input  1  core word write request; never asserted together with proc_read.
- proc_addr  input  30  word address: [1:0] word offset, [INDEX_W+1:2] index, [29:INDEX_W+2] tag.
- proc_wdata  input  32  write data.
- proc_rdata  output  32  read data, valid when proc_read=1 and proc_stall=0.
- proc_stall  output  1  core must hold its request and address while high.
- mem_read  output  1  line fill request to slow memory.
- mem_write  output  1  line write-back request to slow memory.
- mem_addr  output  28  line address (byte address [31:4]).
- mem_wdata  output  128  victim line data.
- mem_rdata  input  128  fill data, valid when mem_ready=1.
- mem_ready  input  1  one-cycle completion pulse from slow memory.

Behaviour:
- Storage per line: valid, dirty, tag[TAG_W], data[128]. Word w of the line occupies bits [32w+31:32w].
- Reset (proc_reset=1 at a clock edge):
  - all valid and dirty bits clear; state becomes IDLE;
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0; proc_stall follows IDLE logic.
  - Reset mid-transaction abandons the transaction; the memory request drops the next cycle.
  - Data arrays need not be reset.
- hit = valid[idx] & (tag[idx]==proc_addr tag). req = proc_read|proc_write.
- IDLE:
  - proc_stall = req & ~hit (combinational).
  - Read hit: proc_rdata = selected word in the same cycle; zero-latency, no state change.
  - Write hit: at the clock edge, the selected word is replaced, dirty[idx]=1, and proc_stall=0.
  - Miss with valid & dirty victim: go to WRITEBACK.
  - Miss otherwise: go to ALLOCATE.
  - proc_rdata when not a read hit: don't-care; the bench must not check it.
- WRITEBACK:
  - Registered outputs: mem_write=1, mem_addr={victim tag, idx}, mem_wdata=victim line, proc_stall=1.
  - Hold until mem_ready=1; then go to ALLOCATE and set dirty[idx]=0.
- ALLOCATE:
  - Registered outputs: mem_read=1, mem_addr={proc_addr tag, idx}, proc_stall=1.
  - When mem_ready=1: line data = mem_rdata, tag updated, valid=1, dirty=0, go to IDLE.
  - The retried access then hits in IDLE, so a write miss merges its word one cycle after the fill.
- Requests are registered and asserted from the first cycle of WRITEBACK/ALLOCATE. They deassert in the cycle after mem_ready is sampled, giving exactly one request per line transfer.
- mem_read and mem_write are never high together.
- mem_ready outside WRITEBACK/ALLOCATE is ignored.
- Miss latency: 1 cycle plus memory latency plus 1 cycle per transfer.
- Index wrap: addresses differing only in tag alias to the same line, which is the eviction path.
- The core changing address while stalled is a protocol violation; behaviour is undefined.

Test Plan:
- Reset, then read addr 0x0000_0004 → proc_stall=1. One mem_read with mem_addr=0x0000001, no mem_write. After mem_ready, proc_rdata = word 0 of the returned line and proc_stall=0.
- Read 0x05 directly after → hit: proc_stall=0 the same cycle, proc_rdata = word 1 of the same line, no memory activity.
- Write 0xDEADBEEF to 0x06 (hit) → no memory traffic. A later read of 0x06 returns 0xDEADBEEF.
- Read 0x26 (same index 1, new tag) → one mem_write at mem_addr=0x0000001 whose wdata[95:64]=0xDEADBEEF. Then one mem_read at mem_addr=0x0000009, in that order.
- Write miss to a clean line, addr 0x10 → mem_read only (no write-back). The line is marked dirty with the new word merged; other words equal the fill data.
- Assert proc_reset while in ALLOCATE with mem_read=1 → mem_read=0 the next cycle, all lines invalid. The next read to any address misses.

Source files
------------

// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache between the core's 32-bit data port
// and a 128-bit line-oriented slow memory. Hits are served combinationally; misses stall the core.
module dcache_wb_dm #(
   parameter int INDEX_W = 3,
   parameter int TAG_W   = 25
) (
   input  logic         clk,
   input  logic         proc_reset,
   input  logic         proc_read,
   input  logic         proc_write,
   input  logic [29:0]  proc_addr,
   input  logic [31:0]  proc_wdata,
   output logic [31:0]  proc_rdata,
   output logic         proc_stall,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready
);

   localparam int LINES = 1 << INDEX_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITEBACK,
      ST_ALLOCATE
   } state_t;

   state_t state_q, state_d;

   logic               mem_read_q, mem_read_d;
   logic               mem_write_q, mem_write_d;
   logic [27:0]        mem_addr_q, mem_addr_d;
   logic [127:0]       mem_wdata_q, mem_wdata_d;

   logic [1:0]         req_offset;
   logic [INDEX_W-1:0] req_index;
   logic [TAG_W-1:0]   req_tag;

   logic [LINES-1:0]   valid_vec;
   logic [LINES-1:0]   dirty_vec;
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [127:0]       data_q [LINES];

   logic [TAG_W-1:0]   line_tag;
   logic [127:0]       line_data;
   logic [127:0]       merged_line;
   logic               line_valid;
   logic               line_dirty;
   logic               hit;
   logic               req;

   // Per-access strobes into the line storage, all addressed by req_index.
   logic               write_word_en;
   logic               fill_en;
   logic               clean_en;

   assign req_offset = proc_addr[1:0];
   assign req_index  = proc_addr[INDEX_W+1:2];
   assign req_tag    = proc_addr[29:INDEX_W+2];

   assign line_tag   = tag_q[req_index];
   assign line_data  = data_q[req_index];
   assign line_valid = valid_vec[req_index];
   assign line_dirty = dirty_vec[req_index];

   assign hit = line_valid & (line_tag == req_tag);
   assign req = proc_read | proc_write;

   assign proc_rdata = line_data[{req_offset, 5'b00000} +: 32];

   always_comb begin
      merged_line = line_data;
      merged_line[{req_offset, 5'b00000} +: 32] = proc_wdata;
   end

   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   always_comb begin
      state_d       = state_q;
      mem_read_d    = mem_read_q;
      mem_write_d   = mem_write_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      proc_stall    = 1'b0;
      write_word_en = 1'b0;
      fill_en       = 1'b0;
      clean_en      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            proc_stall = req & ~hit;
            if (req && !hit) begin
               if (line_valid && line_dirty) begin
                  state_d     = ST_WRITEBACK;
                  mem_write_d = 1'b1;
                  mem_addr_d  = {line_tag, req_index};
                  mem_wdata_d = line_data;
               end else begin
                  state_d    = ST_ALLOCATE;
                  mem_read_d = 1'b1;
                  mem_addr_d = {req_tag, req_index};
               end
            end else if (proc_write && hit) begin
               write_word_en = 1'b1;
            end
         end
         ST_WRITEBACK: begin
            proc_stall = 1'b1;
            if (mem_ready) begin
               // Victim is safely in memory; chain straight into the fill.
               state_d     = ST_ALLOCATE;
               mem_write_d = 1'b0;
               mem_read_d  = 1'b1;
               mem_addr_d  = {req_tag, req_index};
               clean_en    = 1'b1;
            end
         end
         ST_ALLOCATE: begin
            proc_stall = 1'b1;
            if (mem_ready) begin
               state_d    = ST_IDLE;
               mem_read_d = 1'b0;
               fill_en    = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         state_q     <= ST_IDLE;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Tag and data arrays carry no reset; valid bits gate every use of them.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_q[req_index]  <= req_tag;
         data_q[req_index] <= mem_rdata;
      end else if (write_word_en) begin
         data_q[req_index] <= merged_line;
      end
   end

   generate
      for (genvar gi = 0; gi < LINES; gi++) begin : g_line_state
         logic valid_line_q;
         logic dirty_line_q;
         logic line_sel;

         assign line_sel = (req_index == INDEX_W'(gi));

         always_ff @(posedge clk) begin
            if (proc_reset) begin
               valid_line_q <= 1'b0;
               dirty_line_q <= 1'b0;
            end else if (line_sel) begin
               if (fill_en) begin
                  valid_line_q <= 1'b1;
                  dirty_line_q <= 1'b0;
               end else if (clean_en) begin
                  dirty_line_q <= 1'b0;
               end else if (write_word_en) begin
                  dirty_line_q <= 1'b1;
               end
            end
         end

         assign valid_vec[gi] = valid_line_q;
         assign dirty_vec[gi] = dirty_line_q;
      end
   endgenerate

endmodule

// File: tb/tb_dcache_wb_dm.sv
// Directed bench for dcache_wb_dm: read/write hits, clean and dirty misses, eviction ordering,
// and reset during a fill. The bench plays the slow memory by hand.
module tb_dcache_wb_dm;

   logic         clk;
   logic         proc_reset;
   logic         proc_read;
   logic         proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic [31:0]  proc_rdata;
   logic         proc_stall;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;

   int errors = 0;
   int checks = 0;
   int rd_starts = 0;
   int wr_starts = 0;
   int both_high = 0;
   logic prev_rd = 1'b0;
   logic prev_wr = 1'b0;

   logic [127:0] line_a, line_b, line_c, line_d, exp_line, seen;

   dcache_wb_dm #(.INDEX_W(3), .TAG_W(25)) dut (
      .clk        (clk),
      .proc_reset (proc_reset),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_rdata (proc_rdata),
      .proc_stall (proc_stall),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count distinct memory requests (rising edges) and any overlap of read and write.
   always @(negedge clk) begin
      if (mem_read && !prev_rd) rd_starts++;
      if (mem_write && !prev_wr) wr_starts++;
      if (mem_read && mem_write) both_high++;
      prev_rd = mem_read;
      prev_wr = mem_write;
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait for the next memory request, check it, hold it for two cycles, then pulse mem_ready.
   task automatic serve(input string tag, input bit exp_write, input logic [27:0] exp_addr,
                        input logic [127:0] fill, output logic [127:0] wdata_seen);
      int i;
      for (i = 0; i < 20; i++) begin
         if (mem_read || mem_write) break;
         step();
      end
      if (i == 20) chk({tag, "_timeout"}, 128'd1, 128'd0);
      chk({tag, "_mem_write"}, 128'(mem_write), 128'(exp_write));
      chk({tag, "_mem_read"}, 128'(mem_read), 128'(!exp_write));
      chk({tag, "_mem_addr"}, 128'(mem_addr), 128'(exp_addr));
      chk({tag, "_stall"}, 128'(proc_stall), 128'd1);
      wdata_seen = mem_wdata;
      step();
      step();
      chk({tag, "_held"}, 128'(exp_write ? mem_write : mem_read), 128'd1);
      mem_ready = 1'b1;
      mem_rdata = fill;
      step();
      mem_ready = 1'b0;
      mem_rdata = '0;
      chk({tag, "_drop"}, 128'(exp_write ? mem_write : mem_read), 128'd0);
   endtask

   initial begin
      line_a = 128'h3333_3333_2222_2222_1111_1111_0000_0000;
      line_b = 128'hBBBB_0003_BBBB_0002_BBBB_0001_BBBB_0000;
      line_c = 128'hCCCC_0003_CCCC_0002_CCCC_0001_CCCC_0000;
      line_d = 128'hDDDD_0003_DDDD_0002_DDDD_0001_DDDD_0000;
      proc_reset = 1'b1;
      proc_read  = 1'b0;
      proc_write = 1'b0;
      proc_addr  = '0;
      proc_wdata = '0;
      mem_rdata  = '0;
      mem_ready  = 1'b0;
      step();
      step();
      chk("rst_mem_read", 128'(mem_read), 128'd0);
      chk("rst_mem_write", 128'(mem_write), 128'd0);
      chk("rst_mem_addr", 128'(mem_addr), 128'd0);
      chk("rst_mem_wdata", mem_wdata, 128'd0);
      chk("rst_stall_idle", 128'(proc_stall), 128'd0);
      proc_reset = 1'b0;
      step();

      // Cold read miss at 0x04 (index 1, tag 0).
      proc_read = 1'b1;
      proc_addr = 30'h04;
      #1;
      chk("miss04_stall", 128'(proc_stall), 128'd1);
      serve("fill04", 1'b0, 28'h1, line_a, seen);
      chk("miss04_unstall", 128'(proc_stall), 128'd0);
      chk("miss04_rdata", 128'(proc_rdata), 128'(line_a[31:0]));
      chk("miss04_rd_count", 128'(rd_starts), 128'd1);
      chk("miss04_wr_count", 128'(wr_starts), 128'd0);

      // Read hit on word 1, with a stray mem_ready that must be ignored.
      proc_addr = 30'h05;
      #1;
      chk("hit05_stall", 128'(proc_stall), 128'd0);
      chk("hit05_rdata", 128'(proc_rdata), 128'(line_a[63:32]));
      mem_ready = 1'b1;
      mem_rdata = line_d;
      step();
      mem_ready = 1'b0;
      mem_rdata = '0;
      chk("stray_ready_rdata", 128'(proc_rdata), 128'(line_a[63:32]));
      chk("stray_ready_noreq", 128'(mem_read | mem_write), 128'd0);

      // Write hit at 0x06, then read it back.
      proc_read  = 1'b0;
      proc_write = 1'b1;
      proc_addr  = 30'h06;
      proc_wdata = 32'hDEADBEEF;
      #1;
      chk("wr06_stall", 128'(proc_stall), 128'd0);
      step();
      proc_write = 1'b0;
      proc_read  = 1'b1;
      #1;
      chk("rd06_rdata", 128'(proc_rdata), 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
      chk("rd06_stall", 128'(proc_stall), 128'd0);
      chk("rd06_rd_count", 128'(rd_starts), 128'd1);
      chk("rd06_wr_count", 128'(wr_starts), 128'd0);

      // Conflict read 0x26 evicts the dirty line: write-back first, then fill.
      proc_addr = 30'h26;
      #1;
      chk("miss26_stall", 128'(proc_stall), 128'd1);
      serve("wb01", 1'b1, 28'h1, 128'd0, seen);
      exp_line = line_a;
      exp_line[95:64] = 32'hDEADBEEF;
      chk("wb01_word2", 128'(seen[95:64]), 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
      chk("wb01_line", seen, exp_line);
      serve("fill09", 1'b0, 28'h9, line_b, seen);
      chk("miss26_rdata", 128'(proc_rdata), 128'(line_b[95:64]));
      chk("miss26_stall_done", 128'(proc_stall), 128'd0);
      chk("miss26_rd_count", 128'(rd_starts), 128'd2);
      chk("miss26_wr_count", 128'(wr_starts), 128'd1);

      // Write miss to clean (invalid) line 4 at 0x10: fill only, then merge.
      proc_read  = 1'b0;
      proc_write = 1'b1;
      proc_addr  = 30'h10;
      proc_wdata = 32'h12345678;
      #1;
      chk("wmiss10_stall", 128'(proc_stall), 128'd1);
      serve("fill04_line", 1'b0, 28'h4, line_c, seen);
      chk("wmiss10_hit_after", 128'(proc_stall), 128'd0);
      step();
      proc_write = 1'b0;
      proc_read  = 1'b1;
      #1;
      chk("wmiss10_word0", 128'(proc_rdata), 128'h0000_0000_0000_0000_0000_0000_1234_5678);
      proc_addr = 30'h11;
      #1;
      chk("wmiss10_word1", 128'(proc_rdata), 128'(line_c[63:32]));
      proc_addr = 30'h13;
      #1;
      chk("wmiss10_word3", 128'(proc_rdata), 128'(line_c[127:96]));
      chk("wmiss10_wr_count", 128'(wr_starts), 128'd1);

      // Evicting line 4 (read 0x30) must write back the merged, dirty line.
      proc_addr = 30'h30;
      #1;
      chk("miss30_stall", 128'(proc_stall), 128'd1);
      serve("wb04", 1'b1, 28'h4, 128'd0, seen);
      exp_line = line_c;
      exp_line[31:0] = 32'h12345678;
      chk("wb04_line", seen, exp_line);
      serve("fill0c", 1'b0, 28'hC, line_d, seen);
      chk("miss30_rdata", 128'(proc_rdata), 128'(line_d[31:0]));

      // Reset while allocating 0x50 (line 4, tag 2, clean victim).
      proc_addr = 30'h50;
      #1;
      chk("miss50_stall", 128'(proc_stall), 128'd1);
      step();
      chk("miss50_mem_read", 128'(mem_read), 128'd1);
      chk("miss50_no_wb", 128'(mem_write), 128'd0);
      proc_reset = 1'b1;
      step();
      chk("midrst_mem_read", 128'(mem_read), 128'd0);
      chk("midrst_mem_addr", 128'(mem_addr), 128'd0);
      proc_reset = 1'b0;
      proc_read  = 1'b0;
      step();

      // Everything is invalid now: 0x26 misses again, with no write-back.
      proc_read = 1'b1;
      proc_addr = 30'h26;
      #1;
      chk("post_rst_stall", 128'(proc_stall), 128'd1);
      serve("post_rst_fill", 1'b0, 28'h9, line_d, seen);
      chk("post_rst_rdata", 128'(proc_rdata), 128'(line_d[95:64]));
      chk("final_rd_count", 128'(rd_starts), 128'd6);
      chk("final_wr_count", 128'(wr_starts), 128'd2);
      chk("never_both", 128'(both_high), 128'd0);
      proc_read = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
